// File: rtl/divider_32by16_seq.sv
// -----------------------------------------------------------------------------
// divider_32by16_seq
//   Sequential restoring divider: a 2N-bit unsigned dividend divided by an N-bit
//   unsigned divisor gives an N-bit quotient and an N-bit remainder. The divider
//   produces one quotient bit per clock, MSB first. Division by zero and
//   quotient overflow are classified when the operands are accepted. Those cases
//   finish after one cycle and are never iterated.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       request; sampled only while idle (busy==0)
//   dividend    2N-bit unsigned dividend, captured on the accepting edge
//   divisor     N-bit unsigned divisor, captured on the accepting edge
//   quotient    registered quotient, held until the next done
//   remainder   registered remainder, held until the next done
//   busy        high from the accepting edge up to the edge that raises done
//   done        single-cycle pulse, results valid
//   div_by_zero registered with done, divisor was zero
//   overflow    registered with done, dividend high half >= divisor
// -----------------------------------------------------------------------------
module divider_32by16_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam int CW = $clog2(N + 1);

  logic [1:0]    state;
  logic [N-1:0]  dvsr;
  logic [N-1:0]  prem;
  logic [N-1:0]  shreg;
  logic [N-2:0]  qacc;
  logic [CW-1:0] count;
  logic          err_dbz;

  logic          dbz_in;
  logic          ovf_in;
  logic [N:0]    trial;
  logic          qbit;
  logic [N-1:0]  prem_next;
  logic [N-1:0]  q_next;

  // Classify the incoming operands so that error cases skip the iteration.
  always_comb begin
    dbz_in = (divisor == '0);
    ovf_in = !dbz_in && (dividend[2*N-1:N] >= divisor);
  end

  // One restoring step. The trial value keeps the bit shifted out of the
  // partial remainder, so the compare is N+1 bits wide. When the subtraction
  // is taken, the true result is below the divisor and fits in N bits. The
  // low N bits of the difference are therefore exact. Between steps the
  // partial remainder is always below the divisor, so storing it in N bits
  // loses nothing.
  always_comb begin
    trial     = {prem, shreg[N-1]};
    qbit      = (trial >= {1'b0, dvsr});
    prem_next = qbit ? (trial[N-1:0] - dvsr) : trial[N-1:0];
    q_next    = {qacc, qbit};
  end

  // Control FSM and datapath. The done signal defaults low every edge, so it is
  // a one-cycle pulse unless the same edge completes another operation. The low
  // dividend half stays in shreg during ERR, because an error reports it back
  // as the remainder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      dvsr        <= '0;
      prem        <= '0;
      shreg       <= '0;
      qacc        <= '0;
      count       <= '0;
      err_dbz     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            dvsr    <= divisor;
            prem    <= dividend[2*N-1:N];
            shreg   <= dividend[N-1:0];
            qacc    <= '0;
            count   <= CW'(N);
            err_dbz <= dbz_in;
            state   <= (dbz_in || ovf_in) ? S_ERR : S_RUN;
          end
        end
        S_RUN: begin
          prem  <= prem_next;
          shreg <= {shreg[N-2:0], 1'b0};
          qacc  <= q_next[N-2:0];
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= prem_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_ERR: begin
          quotient    <= '1;
          remainder   <= shreg;
          div_by_zero <= err_dbz;
          overflow    <= !err_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
